// File: rtl/post_initiator_if.sv
// Signal bundle between the POST link initiator, its host and the postbox responder.
// master is the initiator's own view; slave is the host/responder side driving it.
interface post_initiator_if;
    logic       testreq;
    logic       testack;
    logic [7:0] out_data;
    logic       out_start;
    logic       in_start;
    logic       busy;
    logic       out_done;
    logic [7:0] in_data;
    logic       in_valid;
    logic       err;

    modport master (
        output testreq, busy, out_done, in_data, in_valid, err,
        input  testack, out_data, out_start, in_start
    );
    modport slave (
        input  testreq, busy, out_done, in_data, in_valid, err,
        output testack, out_data, out_start, in_start
    );
endinterface

// File: rtl/post_initiator.sv
// POST link initiator: OUTPUT/INPUT byte transactions as TESTREQ pulse groups; POST_TRAILING_POLL_EN adds a dummy poll after each OUTPUT.
// Latency: busy the cycle after a start; done/valid/err strobe on the cycle busy falls, after the trailing break.
// Backpressure: starts ignored unless idle; responder not-ready is absorbed by bounded poll retries.
module post_initiator #(
    parameter int PULSE_HIGH   = 24,
    parameter int PULSE_GAP    = 24,
    parameter int BREAK_TICKS  = 960,
    parameter int POLL_RETRIES = 255
) (
    input  logic             refclk,
    input  logic             rst_n,
    post_initiator_if.master bus
);
    localparam int            TW        = $clog2(PULSE_HIGH + PULSE_GAP + BREAK_TICKS + 1);
    localparam logic [TW-1:0] HI_LAST   = TW'(PULSE_HIGH - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(PULSE_GAP - 1);
    localparam logic [TW-1:0] BRK_LAST  = TW'(BREAK_TICKS - 1);
    localparam logic [7:0]    RETRY_MAX = 8'(POLL_RETRIES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_O_POLL,
        ST_O_BIT,
`ifdef POST_TRAILING_POLL_EN
        ST_O_TRAIL,
`endif
        ST_I_HDR,
        ST_I_BIT
    } state_t;

    // What happens when the current low phase expires: another pulse, or finish with a strobe.
    typedef enum logic [1:0] {AF_NONE, AF_DONE, AF_VALID, AF_ERR} after_t;

    state_t        r_state, w_state;
    after_t        r_after, w_after;
    logic          r_hi, w_hi;
    logic [TW-1:0] r_tick, w_tick;
    logic [3:0]    r_pulse, w_pulse;
    logic [2:0]    r_bit, w_bit;
    logic [7:0]    r_retry, w_retry;
    logic [7:0]    r_obyte, w_obyte;
    logic [7:0]    r_ishift, w_ishift;
    logic [7:0]    r_idata, w_idata;
    logic          r_brk, w_brk;
    logic          r_busy, w_busy;
    logic          r_testreq, w_testreq;
    logic          r_out_done, w_out_done;
    logic          r_in_valid, w_in_valid;
    logic          r_err, w_err;
    logic          r_sync1, r_sync2;

    logic          w_ack, w_obit, w_hi_last, w_lo_last;
    logic [7:0]    w_retry_inc;

    assign w_ack       = r_sync2;
    assign w_obit      = r_obyte[r_bit];
    assign w_hi_last   = r_hi && (r_tick == HI_LAST);
    assign w_lo_last   = !r_hi && (r_tick == (r_brk ? BRK_LAST : GAP_LAST));
    assign w_retry_inc = (r_retry == 8'hFF) ? r_retry : r_retry + 8'd1;

    always_comb begin
        w_state    = r_state;
        w_after    = r_after;
        w_hi       = r_hi;
        w_tick     = r_tick + 1'b1;
        w_pulse    = r_pulse;
        w_bit      = r_bit;
        w_retry    = r_retry;
        w_obyte    = r_obyte;
        w_ishift   = r_ishift;
        w_idata    = r_idata;
        w_brk      = r_brk;
        w_busy     = r_busy;
        w_out_done = 1'b0;
        w_in_valid = 1'b0;
        w_err      = 1'b0;

        if (r_state == ST_IDLE) begin
            w_tick = '0;
            if (bus.out_start || bus.in_start) begin
                w_state = bus.out_start ? ST_O_POLL : ST_I_HDR;
                if (bus.out_start) w_obyte = bus.out_data;
                w_hi    = 1'b1;
                w_pulse = '0;
                w_retry = '0;
                w_brk   = 1'b0;
                w_after = AF_NONE;
                w_busy  = 1'b1;
            end
        end else if (w_hi_last) begin
            // Ack decisions are taken on the last high cycle; they pick the following low phase.
            w_hi    = 1'b0;
            w_tick  = '0;
            w_brk   = 1'b0;
            w_pulse = r_pulse + 4'd1;
            case (r_state)
                ST_O_POLL: begin
                    if (r_pulse == 4'd0 && !w_ack) begin
                        w_brk   = 1'b1;
                        w_after = AF_ERR;
                    end else if (r_pulse == 4'd2) begin
                        w_brk   = 1'b1;
                        w_pulse = '0;
                        if (w_ack) begin
                            w_state = ST_O_BIT;
                            w_bit   = 3'd7;
                        end else begin
                            w_retry = w_retry_inc;
                            if (w_retry_inc == RETRY_MAX) w_after = AF_ERR;
                        end
                    end
                end
                ST_O_BIT: begin
                    if (r_pulse == {3'b000, !w_obit}) begin
                        w_brk   = 1'b1;
                        w_pulse = '0;
                        if (r_bit == 3'd0) begin
`ifdef POST_TRAILING_POLL_EN
                            w_state = ST_O_TRAIL;
`else
                            w_after = AF_DONE;
`endif
                        end else begin
                            w_bit = r_bit - 3'd1;
                        end
                    end
                end
`ifdef POST_TRAILING_POLL_EN
                ST_O_TRAIL: begin
                    if (r_pulse == 4'd2) begin
                        w_brk   = 1'b1;
                        w_after = AF_DONE;
                    end
                end
`endif
                ST_I_HDR: begin
                    if (r_pulse == 4'd0 && !w_ack) begin
                        w_brk   = 1'b1;
                        w_after = AF_ERR;
                    end else if (r_pulse >= 4'd3) begin
                        w_pulse = 4'd3;
                        if (w_ack) begin
                            w_state = ST_I_BIT;
                            w_pulse = '0;
                        end else if (r_retry == RETRY_MAX) begin
                            w_brk   = 1'b1;
                            w_after = AF_ERR;
                        end else begin
                            w_retry = w_retry_inc;
                        end
                    end
                end
                ST_I_BIT: begin
                    w_ishift = {r_ishift[6:0], w_ack};
                    if (r_pulse == 4'd7) begin
                        w_brk   = 1'b1;
                        w_after = AF_VALID;
                    end
                end
                default: ;
            endcase
        end else if (w_lo_last) begin
            w_tick = '0;
            if (r_after == AF_NONE) begin
                w_hi = 1'b1;
            end else begin
                w_state    = ST_IDLE;
                w_busy     = 1'b0;
                w_pulse    = '0;
                w_out_done = (r_after == AF_DONE);
                w_in_valid = (r_after == AF_VALID);
                w_err      = (r_after == AF_ERR);
                if (r_after == AF_VALID) w_idata = r_ishift;
            end
        end

        w_testreq = (w_state != ST_IDLE) && w_hi;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_after    <= AF_NONE;
            r_hi       <= 1'b0;
            r_tick     <= '0;
            r_pulse    <= '0;
            r_bit      <= '0;
            r_retry    <= '0;
            r_obyte    <= '0;
            r_ishift   <= '0;
            r_idata    <= '0;
            r_brk      <= 1'b0;
            r_busy     <= 1'b0;
            r_testreq  <= 1'b0;
            r_out_done <= 1'b0;
            r_in_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_after    <= w_after;
            r_hi       <= w_hi;
            r_tick     <= w_tick;
            r_pulse    <= w_pulse;
            r_bit      <= w_bit;
            r_retry    <= w_retry;
            r_obyte    <= w_obyte;
            r_ishift   <= w_ishift;
            r_idata    <= w_idata;
            r_brk      <= w_brk;
            r_busy     <= w_busy;
            r_testreq  <= w_testreq;
            r_out_done <= w_out_done;
            r_in_valid <= w_in_valid;
            r_err      <= w_err;
        end
    end

    // testack is asynchronous to refclk.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.testack;
            r_sync2 <= r_sync1;
        end
    end

    assign bus.testreq  = r_testreq;
    assign bus.busy     = r_busy;
    assign bus.out_done = r_out_done;
    assign bus.in_valid = r_in_valid;
    assign bus.err      = r_err;
    assign bus.in_data  = r_idata;
endmodule

// File: tb/tb_post_initiator.sv
// Bench for post_initiator: behavioural responder plus pulse-group monitor, directed and random transactions.
module tb_post_initiator;
    localparam int HI = 8, GAP = 6, BRK = 40, PR = 5, THR = 20;
    localparam int M_OUT = 0, M_IN = 1, M_DEAD = 2;

    logic refclk = 1'b0;
    logic rst_n  = 1'b1;

    post_initiator_if pif();

    post_initiator #(
        .PULSE_HIGH(HI), .PULSE_GAP(GAP), .BREAK_TICKS(BRK), .POLL_RETRIES(PR)
    ) dut (
        .refclk(refclk),
        .rst_n (rst_n),
        .bus   (pif)
    );

    always #5 refclk = ~refclk;

    int         checks = 0, errors = 0;
    int         mode = M_DEAD, m_n = 0;
    logic [7:0] m_val = 8'h00;
    int         hirun = 0, lowrun = 0, npulse = 0, grp_idx = 0;
    logic       prev_req = 1'b0, prev_busy = 1'b0;
    int         grp_q[$];
    int         done_cnt = 0, valid_cnt = 0, err_cnt = 0;
    logic       ack3 = 1'b0, accepted = 1'b0;
    logic [7:0] rxout = 8'h00, exp_in = 8'h00;
    bit         found;
    int         rk, rn;
    logic [7:0] rv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Responder policy: what a postbox would answer on pulse p (1-based) of group g.
    function automatic logic resp_ack(input int g, input int p);
        int k;
        case (mode)
            M_OUT: return (p == 3) ? (g >= m_n) : 1'b1;
            M_IN: begin
                if (p <= 3) return 1'b1;
                if (p < 4 + m_n) return 1'b0;
                if (p == 4 + m_n) return 1'b1;
                k = p - (5 + m_n);
                if (k <= 7) return m_val[7-k];
                return 1'b0;
            end
            default: return 1'b0;
        endcase
    endfunction

    always @(negedge refclk) begin
        if (!rst_n) begin
            hirun = 0; lowrun = 0; npulse = 0;
            prev_req = 1'b0; prev_busy = 1'b0;
            pif.testack = 1'b0;
        end else begin
            if (pif.out_done) done_cnt++;
            if (pif.in_valid) valid_cnt++;
            if (pif.err)      err_cnt++;
            if (pif.out_done || pif.in_valid || pif.err)
                chk("strobe_on_busy_fall", {prev_busy, pif.busy}, 2'b10);
            if (prev_busy && !pif.busy) chk("break_before_idle", lowrun, BRK);
            if (pif.testreq && !prev_req) begin
                chk("low_width", (lowrun == GAP) || (lowrun >= BRK), 1);
                npulse++;
                hirun = 0;
                pif.testack = resp_ack(grp_idx, npulse);
                if (npulse == 3) ack3 = pif.testack;
            end
            if (!pif.testreq && prev_req) begin
                chk("high_width", hirun, HI);
                pif.testack = 1'b0;
                lowrun = 0;
            end
            if (pif.testreq) hirun++;
            else begin
                lowrun++;
                if (lowrun == THR && npulse > 0) begin
                    if (mode == M_OUT) begin
                        if (npulse == 3 && ack3) accepted = 1'b1;
                        else if (accepted && npulse <= 2) rxout = {rxout[6:0], npulse == 1};
                    end
                    grp_q.push_back(npulse);
                    grp_idx++;
                    npulse = 0;
                end
            end
            prev_req  = pif.testreq;
            prev_busy = pif.busy;
        end
    end

    task automatic begin_txn(input int kind, input logic [7:0] val, input int n);
        mode = kind; m_val = val; m_n = n;
        grp_q.delete(); grp_idx = 0;
        done_cnt = 0; valid_cnt = 0; err_cnt = 0;
        accepted = 1'b0; rxout = 8'h00;
    endtask

    task automatic run_txn(input int kind, input logic [7:0] val, input int n, input bit both);
        int exp_q[$];
        int e_done, e_valid, e_err, polls;
        bit fin;
        e_done = 0; e_valid = 0; e_err = 0;
        case (kind)
            M_OUT: begin
                polls = (n >= PR) ? PR : n + 1;
                repeat (polls) exp_q.push_back(3);
                if (n < PR) begin
                    for (int i = 7; i >= 0; i--) exp_q.push_back(val[i] ? 1 : 2);
`ifdef POST_TRAILING_POLL_EN
                    exp_q.push_back(3);
`endif
                    e_done = 1;
                end else e_err = 1;
            end
            M_IN: begin
                if (n <= PR) begin exp_q.push_back(12 + n); e_valid = 1; end
                else begin exp_q.push_back(4 + PR); e_err = 1; end
            end
            default: begin exp_q.push_back(1); e_err = 1; end
        endcase

        begin_txn(kind, val, n);
        @(posedge refclk); #1;
        pif.out_data = val;
        if (kind == M_IN) pif.in_start = 1'b1; else pif.out_start = 1'b1;
        if (both) pif.in_start = 1'b1;
        @(negedge refclk);
        chk("busy_before_start", pif.busy, 0);
        @(posedge refclk); #1;
        pif.out_start = 1'b0; pif.in_start = 1'b0;
        pif.out_data = 8'($urandom);
        chk("busy_after_start", pif.busy, 1);

        fin = 1'b0;
        for (int c = 0; c < 20000 && !fin; c++) begin
            @(negedge refclk);
            pif.out_start = 1'b0; pif.in_start = 1'b0;
            if (!pif.busy) fin = 1'b1;
            else if (c == 50) begin pif.out_start = 1'b1; pif.in_start = 1'b1; end
        end
        chk("busy_fall_in_budget", fin, 1);
        repeat (3) @(negedge refclk);
        chk("busy_stays_low", pif.busy, 0);

        chk("group_count", grp_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < grp_q.size()) chk("group_pulses", grp_q[i], exp_q[i]);
        chk("out_done_count", done_cnt, e_done);
        chk("in_valid_count", valid_cnt, e_valid);
        chk("err_count", err_cnt, e_err);
        if (kind == M_OUT && n < PR) chk("responder_rx_byte", rxout, val);
        if (e_valid != 0) exp_in = val;
        chk("in_data", pif.in_data, exp_in);
    endtask

    initial begin
        pif.out_start = 1'b0; pif.in_start = 1'b0; pif.out_data = 8'h00; pif.testack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_testreq", pif.testreq, 0);
        chk("rst_busy", pif.busy, 0);
        chk("rst_strobes", {pif.out_done, pif.in_valid, pif.err}, 3'b000);
        chk("rst_in_data", pif.in_data, 8'h00);
        repeat (3) @(posedge refclk);
        #1 rst_n = 1'b1;
        repeat (BRK + 10) @(negedge refclk);

        run_txn(M_OUT, 8'hA5, 0, 1'b0);
        run_txn(M_OUT, 8'h5A, 2, 1'b0);
        run_txn(M_IN, 8'h3C, 0, 1'b0);
        run_txn(M_IN, 8'h00, PR + 1, 1'b0);
        run_txn(M_DEAD, 8'h77, 0, 1'b0);
        run_txn(M_OUT, 8'h96, PR, 1'b0);
        run_txn(M_OUT, 8'hC3, 1, 1'b1);

        // Reset in the middle of bit 3 of 0xF0 (groups: poll, bits 7..4, then bit 3).
        begin_txn(M_OUT, 8'hF0, 0);
        @(posedge refclk); #1;
        pif.out_data = 8'hF0; pif.out_start = 1'b1;
        @(posedge refclk); #1;
        pif.out_start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 5000 && !found; c++) begin
            @(negedge refclk);
            if (grp_idx == 5 && npulse == 1) found = 1'b1;
        end
        chk("reached_bit3", found, 1);
        repeat (3) @(posedge refclk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_testreq", pif.testreq, 0);
        chk("mid_rst_busy", pif.busy, 0);
        chk("mid_rst_strobes", {pif.out_done, pif.in_valid, pif.err}, 3'b000);
        repeat (4) @(negedge refclk);
        #1 rst_n = 1'b1;
        repeat (BRK + 10) @(negedge refclk);
        chk("post_rst_strobes", done_cnt + valid_cnt + err_cnt, 0);
        chk("post_rst_busy", pif.busy, 0);
        exp_in = 8'h00;
        run_txn(M_OUT, 8'h01, 0, 1'b0);

        for (int t = 0; t < 14; t++) begin
            rk = int'($urandom_range(1, 0));
            rv = 8'($urandom);
            rn = (rk == M_OUT) ? int'($urandom_range(PR, 0)) : int'($urandom_range(PR + 1, 0));
            run_txn(rk, rv, rn, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/post_initiator.md
Name: post_initiator

Overview:
- Target-side end of the RISC OS POST debug link; drives TESTREQ pulse trains and samples TESTACK.
- Executes OUTPUT (byte to the postbox) and INPUT (byte from the postbox) transactions.
- Lets the postbox responder be exercised in simulation and on hardware without a real target.
- Fully synchronous to refclk (48 MHz); host side uses simple start/done strobes.

Parameters:
- PULSE_HIGH, 24: TESTREQ high width in refclk ticks (500 ns); minimum 8.
- PULSE_GAP, 24: TESTREQ low time between pulses of one group.
- BREAK_TICKS, 960: low time ending a group (20 us); must exceed the responder's 480-tick timeout.
- POLL_RETRIES, 255: poll attempts (OUTPUT) or repeated 4th pulses (INPUT) before giving up.

Ports:
- refclk  in  1  48 MHz clock
- rst_n  in  1  asynchronous active-low reset
- testreq  out  1  TESTREQ (LA23) to the responder
- testack  in  1  TESTACK from the responder; asynchronous
- out_data  in  8  byte to send (OUTPUT)
- out_start  in  1  strobe: start OUTPUT with out_data
- in_start  in  1  strobe: start INPUT
- busy  out  1  transaction in progress
- out_done  out  1  1-cycle strobe: OUTPUT completed
- in_data  out  8  received byte, held until the next INPUT completes
- in_valid  out  1  1-cycle strobe: in_data updated
- err  out  1  1-cycle strobe: retries exhausted, or no ack on pulse 1

Behaviour:
- Reset values (async, rst_n low): testreq=0, busy=0, out_done=0, in_valid=0, err=0, in_data=0x00, state IDLE, all counters 0.
- testack passes through a 2-flop synchroniser.
- Ack for a pulse = synchronised testack sampled on the last high cycle of that pulse.
- Pulse engine:
  - HI: PULSE_HIGH cycles, testreq=1.
  - Then LO: PULSE_GAP cycles if more pulses follow in the group, otherwise BREAK_TICKS cycles.
  - testreq is registered; it is never glitched.
- Start handling:
  - Starts are accepted only in IDLE.
  - busy rises the cycle after the start.
  - If out_start and in_start arrive together, out_start wins; in_start is dropped.
  - Starts while busy are ignored.
  - out_data is latched at the start.
- States:
  - IDLE
  - O_POLL: 3-pulse group.
    - Ack on pulse 1 = 0: err, then IDLE.
    - Ack on pulse 3 = 1: break, then O_BIT.
    - Ack on pulse 3 = 0: break, retry counter +1, repeat O_POLL; when the count reaches POLL_RETRIES: err, then IDLE.
  - O_BIT: sends bits 7..0, MSB first. Bit 1 = one-pulse group, bit 0 = two-pulse group, each followed by a break. After bit 0's break: out_done, then IDLE (or O_TRAIL when the feature is enabled).
  - I_HDR: 4 pulses with gaps, no break. Ack on pulse 1 = 0: err.
    - Ack on pulse 4 = 1: go to I_BIT.
    - Ack on pulse 4 = 0: further single pulses (gap only), each sampled, until ack or POLL_RETRIES extra pulses.
    - On exhaustion: break, err, then IDLE.
  - I_BIT: 8 more pulses, gap-separated. Ack of pulse k is shifted into in_data MSB first. After the 8th pulse: break, in_data updated, in_valid, then IDLE.
- Done, in_valid and err strobes fire on the cycle busy falls.
- busy falls only after the trailing break completes, so back-to-back transactions keep protocol spacing.
- Retry counter: 8 bits, saturating, cleared at each start.
- rst_n asserted mid-transaction: testreq drops to 0 immediately; no strobe is issued. The responder recovers on its own timeout.

Optional Feature:
- Macro: POST_TRAILING_POLL_EN.
- Defined: after each OUTPUT byte, O_TRAIL sends one dummy 3-pulse poll plus break, ignoring its ack; then out_done.
- Undefined: O_TRAIL is absent; out_done follows bit 0's break directly.

Test Plan:
- OUTPUT 0xA5, responder always acks:
  - Groups seen: 3, then 1,2,1,2,2,1,2,1 pulses.
  - One out_done; err never asserted.
  - Responder rxout=0xA5.
- OUTPUT with responder rx full for 2 polls, then freed: exactly 3 poll groups precede the data; byte delivered intact.
- INPUT with responder loaded with 0x3C:
  - Ack on pulse 4; 8 further pulses.
  - in_data=0x3C, one in_valid.
  - Total 12 pulses, then break.
- INPUT with empty responder, POLL_RETRIES=5: 4+5 pulses, break, err strobe, in_data unchanged.
- testack tied low: first pulse unacked gives err after the first group; busy then clears.
- rst_n pulsed during O_BIT bit 3:
  - testreq=0 asynchronously; busy=0; no strobes.
  - A subsequent OUTPUT of 0x01 completes normally.
